fu_iss_skid: RTL and testbench
==============================

Name: fu_iss_skid

Overview:
- Two-entry issue buffer between the RS issue port and fu_main.
- Registers the selected instruction packet and PRF operand values, and presents them to fu_main one cycle later.
- Absorbs fu_main's load-commit stall without dropping an issued instruction.
- Applies branch-mask squash and fix while the packet is in flight, so fu_main never receives a packet that is dead or has stale branch-mask bits.

Parameters:
- BR_MASK_W, 5, branch-mask width (one-hot tag space).
- ROB_IDX_W, 5, ROB index width; the index field carries one extra wrap bit.
- PRF_IDX_W, 6, physical register tag width.
- FU_SEL_W, 3, functional-unit select width.
- SQ_IDX_W, 3, store-queue index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- iss_vld_i  in  1  RS issues a packet this cycle.
- iss_rdy_o  out  1  buffer can accept a packet this cycle.
- iss_sel_i  in  FU_SEL_W  unit select.
- iss_IR_i  in  32  instruction word.
- iss_NPC_i  in  64  next PC.
- iss_rob_idx_i  in  ROB_IDX_W+1  ROB index.
- iss_dest_tag_i  in  PRF_IDX_W  destination tag.
- iss_br_mask_i  in  BR_MASK_W  branch dependency mask.
- iss_br_mask_1hot_i  in  BR_MASK_W  own branch tag (branches only).
- iss_br_pre_taken_i  in  1  predicted direction.
- iss_br_target_i  in  64  predicted target.
- iss_sq_idx_i  in  SQ_IDX_W  store-queue index.
- prf_ra_value_i  in  64  operand A.
- prf_rb_value_i  in  64  operand B.
- fu_stall_i  in  1  fu_main stall (lsq_lq_com_rdy_stall_o).
- rob_br_recovery_i  in  1  mispredict recovery this cycle.
- rob_br_pred_correct_i  in  1  branch resolved correct this cycle.
- rob_br_tag_fix_i  in  BR_MASK_W  one-hot tag being resolved.
- fu_vld_o  out  1  head packet valid; maps to rs2fu_iss_vld_i.
- fu_sel_o, fu_IR_o, fu_NPC_o, fu_rob_idx_o, fu_dest_tag_o, fu_br_mask_o, fu_br_mask_1hot_o, fu_br_pre_taken_o, fu_br_target_o, fu_sq_idx_o, fu_ra_value_o, fu_rb_value_o  out  (same widths as the inputs)  head packet fields.

Behaviour:
- Storage: head entry H, which drives the fu_* outputs, and skid entry S. Each has a valid bit and a full payload.
- Reset (rst=0, asynchronous): both valid bits 0, all payload 0, fu_sel_o = `FU_SEL_NONE, fu_dest_tag_o = `ZERO_REG. Consequently fu_vld_o=0 and iss_rdy_o=1.
- iss_rdy_o = ~S.valid. It is purely registered-state driven, with no combinational path from fu_stall_i.
- Push = iss_vld_i & iss_rdy_o. Pop = H.valid & ~fu_stall_i.
- Latency: a packet pushed in cycle N appears on fu_* in cycle N+1 at the earliest.
- State update (evaluated on post-squash valids):
  - Neither valid, push: load H.
  - H only, pop and push: H <- incoming.
  - H only, no pop, push: S <- incoming.
  - H only, pop, no push: H empties.
  - H and S, pop: H <- S, S empties. No push is possible, because iss_rdy_o=0.
  - H and S, no pop: hold.
- Ordering: packets leave in push order.
- fu_vld_o = H.valid. When H is invalid, fu_sel_o = `FU_SEL_NONE, so fu_main's ex_unit_en is zero.
- Recovery (rob_br_recovery_i=1): every stored entry with (br_mask & tag_fix) != 0 is invalidated, and an incoming packet matching that condition is not pushed. Independent entries survive.
  - If H is killed and S survives, S moves to H in the same edge.
  - A killed H is not counted as a pop.
  - fu_vld_o drops in the cycle after recovery. The same-cycle output is already masked inside fu_main.
- Correct prediction (rob_br_pred_correct_i=1): br_mask &= ~tag_fix on H, on S, and on the incoming packet before it is stored.
- Simultaneous recovery and pred_correct with different tags: apply squash first, then clear on survivors.
- Stall with H invalid has no effect. A stall does not block filling an empty H.
- Operand values are captured at push and never re-read.

Decomposition:
- Shared package: a packed iss_pkt_t struct (every payload field above), the FU_SEL_* and ZERO_REG constants, and a br_dep(mask, tag) function.
- Sub-module: iss_pkt_brfix, purely combinational. Inputs are a packet, recovery, pred_correct and tag_fix; outputs are kill and the updated packet. It is instantiated three times: H, S, incoming.

Test Plan:
- Single ALU packet: push rob_idx=3, dest=12, ra=5, rb=7 with no stall -> fu_vld_o=1 next cycle with identical fields; deasserts the cycle after.
- Stall skid: hold fu_stall_i=1 and push packets A then B -> A held on outputs, iss_rdy_o=0 after B. Release the stall -> A for one cycle, then B, then fu_vld_o=0; iss_rdy_o returns to 1.
- Recovery kill: H mask=5'b00010, S mask=5'b00001, recovery with tag_fix=5'b00010 -> H dropped, S on outputs the next cycle with mask unchanged.
- Pred correct: H mask=5'b00110, pred_correct with tag_fix=5'b00100 -> fu_br_mask_o=5'b00010 the next cycle. An incoming packet with mask=5'b00100 in the same cycle is stored with mask 0.
- Incoming squash: push mask=5'b01000 in the same cycle as recovery with tag_fix=5'b01000 -> nothing stored, fu_vld_o=0, iss_rdy_o=1.
- Reset mid-operation: assert rst=0 with H and S full -> asynchronously fu_vld_o=0, iss_rdy_o=1, fu_sel_o=`FU_SEL_NONE.

Source files
------------

// File: rtl/fu_iss_skid_pkg.sv
// Shared types and helpers for the RS-to-fu_main issue skid buffer.
// No logic; constants, packet layout, branch-dependency test.
// No backpressure of its own.
package fu_iss_skid_pkg;

    localparam int BR_MASK_W = 5;
    localparam int ROB_IDX_W = 5;
    localparam int PRF_IDX_W = 6;
    localparam int FU_SEL_W  = 3;
    localparam int SQ_IDX_W  = 3;

    localparam logic [FU_SEL_W-1:0]  FU_SEL_NONE = '0;
    localparam logic [PRF_IDX_W-1:0] ZERO_REG    = PRF_IDX_W'(31);

    typedef struct packed {
        logic [FU_SEL_W-1:0]  sel;
        logic [31:0]          ir;
        logic [63:0]          npc;
        logic [ROB_IDX_W:0]   rob_idx;
        logic [PRF_IDX_W-1:0] dest_tag;
        logic [BR_MASK_W-1:0] br_mask;
        logic [BR_MASK_W-1:0] br_mask_1hot;
        logic                 br_pre_taken;
        logic [63:0]          br_target;
        logic [SQ_IDX_W-1:0]  sq_idx;
        logic [63:0]          ra_value;
        logic [63:0]          rb_value;
    } iss_pkt_t;

    localparam iss_pkt_t PKT_RST = '{sel: FU_SEL_NONE, dest_tag: ZERO_REG, default: '0};

    function automatic logic br_dep(input logic [BR_MASK_W-1:0] mask,
                                    input logic [BR_MASK_W-1:0] tag);
        return |(mask & tag);
    endfunction

endpackage

// File: rtl/iss_pkt_brfix.sv
// Branch squash/fix for one in-flight issue packet.
// Purely combinational, zero latency.
// No backpressure; kill tells the owner to drop the packet.
module iss_pkt_brfix
    import fu_iss_skid_pkg::*;
(
    input  iss_pkt_t             pkt,
    input  logic                 recovery,
    input  logic                 pred_correct,
    input  logic [BR_MASK_W-1:0] tag_fix,
    output logic                 kill,
    output iss_pkt_t             pkt_fixed
);

    // Kill is judged on the original mask, so a squash always wins over a clear.
    always_comb begin
        kill      = recovery & br_dep(pkt.br_mask, tag_fix);
        pkt_fixed = pkt;
        if (pred_correct) begin
            pkt_fixed.br_mask = pkt.br_mask & ~tag_fix;
        end
    end

endmodule

// File: rtl/fu_iss_skid.sv
// Two-entry issue skid buffer (head H drives fu_*, skid S absorbs a stall).
// Latency: one cycle from push to fu_* output.
// Backpressure: iss_rdy_o = ~S.valid, registered only; fu_stall_i holds H.
module fu_iss_skid
    import fu_iss_skid_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iss_vld_i,
    output logic                 iss_rdy_o,
    input  logic [FU_SEL_W-1:0]  iss_sel_i,
    input  logic [31:0]          iss_IR_i,
    input  logic [63:0]          iss_NPC_i,
    input  logic [ROB_IDX_W:0]   iss_rob_idx_i,
    input  logic [PRF_IDX_W-1:0] iss_dest_tag_i,
    input  logic [BR_MASK_W-1:0] iss_br_mask_i,
    input  logic [BR_MASK_W-1:0] iss_br_mask_1hot_i,
    input  logic                 iss_br_pre_taken_i,
    input  logic [63:0]          iss_br_target_i,
    input  logic [SQ_IDX_W-1:0]  iss_sq_idx_i,
    input  logic [63:0]          prf_ra_value_i,
    input  logic [63:0]          prf_rb_value_i,
    input  logic                 fu_stall_i,
    input  logic                 rob_br_recovery_i,
    input  logic                 rob_br_pred_correct_i,
    input  logic [BR_MASK_W-1:0] rob_br_tag_fix_i,
    output logic                 fu_vld_o,
    output logic [FU_SEL_W-1:0]  fu_sel_o,
    output logic [31:0]          fu_IR_o,
    output logic [63:0]          fu_NPC_o,
    output logic [ROB_IDX_W:0]   fu_rob_idx_o,
    output logic [PRF_IDX_W-1:0] fu_dest_tag_o,
    output logic [BR_MASK_W-1:0] fu_br_mask_o,
    output logic [BR_MASK_W-1:0] fu_br_mask_1hot_o,
    output logic                 fu_br_pre_taken_o,
    output logic [63:0]          fu_br_target_o,
    output logic [SQ_IDX_W-1:0]  fu_sq_idx_o,
    output logic [63:0]          fu_ra_value_o,
    output logic [63:0]          fu_rb_value_o
);

    iss_pkt_t h_pkt, s_pkt, in_pkt;
    iss_pkt_t h_fix, s_fix, in_fix;
    iss_pkt_t h_nxt, s_nxt;
    logic     h_vld, s_vld;
    logic     h_kill, s_kill, in_kill;
    logic     h_live, s_live;
    logic     push, pop;
    logic     h_vld_nxt, s_vld_nxt;

    always_comb begin
        in_pkt              = PKT_RST;
        in_pkt.sel          = iss_sel_i;
        in_pkt.ir           = iss_IR_i;
        in_pkt.npc          = iss_NPC_i;
        in_pkt.rob_idx      = iss_rob_idx_i;
        in_pkt.dest_tag     = iss_dest_tag_i;
        in_pkt.br_mask      = iss_br_mask_i;
        in_pkt.br_mask_1hot = iss_br_mask_1hot_i;
        in_pkt.br_pre_taken = iss_br_pre_taken_i;
        in_pkt.br_target    = iss_br_target_i;
        in_pkt.sq_idx       = iss_sq_idx_i;
        in_pkt.ra_value     = prf_ra_value_i;
        in_pkt.rb_value     = prf_rb_value_i;
    end

    iss_pkt_brfix u_fix_h (
        .pkt          (h_pkt),
        .recovery     (rob_br_recovery_i),
        .pred_correct (rob_br_pred_correct_i),
        .tag_fix      (rob_br_tag_fix_i),
        .kill         (h_kill),
        .pkt_fixed    (h_fix)
    );

    iss_pkt_brfix u_fix_s (
        .pkt          (s_pkt),
        .recovery     (rob_br_recovery_i),
        .pred_correct (rob_br_pred_correct_i),
        .tag_fix      (rob_br_tag_fix_i),
        .kill         (s_kill),
        .pkt_fixed    (s_fix)
    );

    iss_pkt_brfix u_fix_in (
        .pkt          (in_pkt),
        .recovery     (rob_br_recovery_i),
        .pred_correct (rob_br_pred_correct_i),
        .tag_fix      (rob_br_tag_fix_i),
        .kill         (in_kill),
        .pkt_fixed    (in_fix)
    );

    assign iss_rdy_o = ~s_vld;
    assign h_live    = h_vld & ~h_kill;
    assign s_live    = s_vld & ~s_kill;
    assign push      = iss_vld_i & iss_rdy_o & ~in_kill;
    // A squashed head was never consumed, so it does not count as a pop.
    assign pop       = h_live & ~fu_stall_i;

    always_comb begin
        h_vld_nxt = h_live;
        s_vld_nxt = s_live;
        h_nxt     = h_fix;
        s_nxt     = s_fix;
        if (!h_live) begin
            if (s_live) begin
                h_vld_nxt = 1'b1;
                h_nxt     = s_fix;
                s_vld_nxt = 1'b0;
            end else if (push) begin
                h_vld_nxt = 1'b1;
                h_nxt     = in_fix;
            end
        end else if (!s_live) begin
            if (pop) begin
                h_vld_nxt = push;
                if (push) begin
                    h_nxt = in_fix;
                end
            end else if (push) begin
                s_vld_nxt = 1'b1;
                s_nxt     = in_fix;
            end
        end else if (pop) begin
            h_nxt     = s_fix;
            s_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_vld <= 1'b0;
            s_vld <= 1'b0;
            h_pkt <= PKT_RST;
            s_pkt <= PKT_RST;
        end else begin
            h_vld <= h_vld_nxt;
            s_vld <= s_vld_nxt;
            h_pkt <= h_nxt;
            s_pkt <= s_nxt;
        end
    end

    assign fu_vld_o          = h_vld;
    assign fu_sel_o          = h_vld ? h_pkt.sel : FU_SEL_NONE;
    assign fu_IR_o           = h_pkt.ir;
    assign fu_NPC_o          = h_pkt.npc;
    assign fu_rob_idx_o      = h_pkt.rob_idx;
    assign fu_dest_tag_o     = h_pkt.dest_tag;
    assign fu_br_mask_o      = h_pkt.br_mask;
    assign fu_br_mask_1hot_o = h_pkt.br_mask_1hot;
    assign fu_br_pre_taken_o = h_pkt.br_pre_taken;
    assign fu_br_target_o    = h_pkt.br_target;
    assign fu_sq_idx_o       = h_pkt.sq_idx;
    assign fu_ra_value_o     = h_pkt.ra_value;
    assign fu_rb_value_o     = h_pkt.rb_value;

endmodule

// File: tb/tb_fu_iss_skid.sv
// Bench for fu_iss_skid: directed scenarios plus random traffic vs a queue model.
module tb_fu_iss_skid;
    import fu_iss_skid_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 iss_vld = 1'b0;
    logic                 iss_rdy;
    iss_pkt_t             in_pkt = PKT_RST;
    logic                 fu_stall = 1'b0;
    logic                 recov = 1'b0;
    logic                 pcorr = 1'b0;
    logic [BR_MASK_W-1:0] tag_fix = '0;

    logic                 fu_vld;
    iss_pkt_t             obs;
    logic [FU_SEL_W-1:0]  o_sel;
    logic [31:0]          o_ir;
    logic [63:0]          o_npc, o_tgt, o_ra, o_rb;
    logic [ROB_IDX_W:0]   o_rob;
    logic [PRF_IDX_W-1:0] o_dest;
    logic [BR_MASK_W-1:0] o_mask, o_1hot;
    logic                 o_taken;
    logic [SQ_IDX_W-1:0]  o_sq;

    int checks = 0;
    int errors = 0;
    iss_pkt_t q[$];

    always #5 clk = ~clk;

    fu_iss_skid dut (
        .clk(clk), .rst(rst),
        .iss_vld_i(iss_vld), .iss_rdy_o(iss_rdy),
        .iss_sel_i(in_pkt.sel), .iss_IR_i(in_pkt.ir), .iss_NPC_i(in_pkt.npc),
        .iss_rob_idx_i(in_pkt.rob_idx), .iss_dest_tag_i(in_pkt.dest_tag),
        .iss_br_mask_i(in_pkt.br_mask), .iss_br_mask_1hot_i(in_pkt.br_mask_1hot),
        .iss_br_pre_taken_i(in_pkt.br_pre_taken), .iss_br_target_i(in_pkt.br_target),
        .iss_sq_idx_i(in_pkt.sq_idx),
        .prf_ra_value_i(in_pkt.ra_value), .prf_rb_value_i(in_pkt.rb_value),
        .fu_stall_i(fu_stall), .rob_br_recovery_i(recov),
        .rob_br_pred_correct_i(pcorr), .rob_br_tag_fix_i(tag_fix),
        .fu_vld_o(fu_vld), .fu_sel_o(o_sel), .fu_IR_o(o_ir), .fu_NPC_o(o_npc),
        .fu_rob_idx_o(o_rob), .fu_dest_tag_o(o_dest), .fu_br_mask_o(o_mask),
        .fu_br_mask_1hot_o(o_1hot), .fu_br_pre_taken_o(o_taken),
        .fu_br_target_o(o_tgt), .fu_sq_idx_o(o_sq),
        .fu_ra_value_o(o_ra), .fu_rb_value_o(o_rb)
    );

    always_comb begin
        obs              = PKT_RST;
        obs.sel          = o_sel;
        obs.ir           = o_ir;
        obs.npc          = o_npc;
        obs.rob_idx      = o_rob;
        obs.dest_tag     = o_dest;
        obs.br_mask      = o_mask;
        obs.br_mask_1hot = o_1hot;
        obs.br_pre_taken = o_taken;
        obs.br_target    = o_tgt;
        obs.sq_idx       = o_sq;
        obs.ra_value     = o_ra;
        obs.rb_value     = o_rb;
    end

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic iss_pkt_t rand_pkt(input logic [BR_MASK_W-1:0] mask);
        iss_pkt_t p;
        p.sel          = FU_SEL_W'($urandom_range(1, 7));
        p.ir           = $urandom;
        p.npc          = {$urandom, $urandom};
        p.rob_idx      = (ROB_IDX_W+1)'($urandom);
        p.dest_tag     = PRF_IDX_W'($urandom);
        p.br_mask      = mask;
        p.br_mask_1hot = BR_MASK_W'(1) << $urandom_range(0, BR_MASK_W-1);
        p.br_pre_taken = 1'($urandom);
        p.br_target    = {$urandom, $urandom};
        p.sq_idx       = SQ_IDX_W'($urandom);
        p.ra_value     = {$urandom, $urandom};
        p.rb_value     = {$urandom, $urandom};
        return p;
    endfunction

    // Ordered queue of live packets; q[0] is what fu_main should see.
    task automatic model_step();
        iss_pkt_t nq[$];
        iss_pkt_t p;
        int  sz = q.size();
        bit  popped;
        popped = sz > 0 && !fu_stall && !(recov && (q[0].br_mask & tag_fix) != 0);
        for (int i = 0; i < sz; i++) begin
            p = q[i];
            if (recov && (p.br_mask & tag_fix) != 0) continue;
            if (i == 0 && popped) continue;
            if (pcorr) p.br_mask = p.br_mask & ~tag_fix;
            nq.push_back(p);
        end
        if (iss_vld && sz < 2 && !(recov && (in_pkt.br_mask & tag_fix) != 0)) begin
            p = in_pkt;
            if (pcorr) p.br_mask = p.br_mask & ~tag_fix;
            nq.push_back(p);
        end
        q = nq;
    endtask

    task automatic compare_model();
        check("vld", 320'(fu_vld), 320'(q.size() > 0));
        check("rdy", 320'(iss_rdy), 320'(q.size() < 2));
        if (q.size() > 0) check("pkt", 320'(obs), 320'(q[0]));
        else              check("sel_none", 320'(o_sel), 320'(FU_SEL_NONE));
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle();
        iss_vld = 1'b0; fu_stall = 1'b0; recov = 1'b0; pcorr = 1'b0; tag_fix = '0;
    endtask

    iss_pkt_t a, b;

    initial begin
        #12;
        check("rst_vld", 320'(fu_vld), 320'(0));
        check("rst_rdy", 320'(iss_rdy), 320'(1));
        check("rst_sel", 320'(o_sel), 320'(FU_SEL_NONE));
        check("rst_dest", 320'(o_dest), 320'(ZERO_REG));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single ALU packet
        a = rand_pkt('0);
        a.rob_idx = 3; a.dest_tag = 12; a.ra_value = 5; a.rb_value = 7; a.sel = 3'd1;
        in_pkt = a; iss_vld = 1'b1;
        tick();
        check("alu_vld", 320'(fu_vld), 320'(1));
        check("alu_rob", 320'(o_rob), 320'(3));
        check("alu_ra", 320'(o_ra), 320'(5));
        check("alu_rb", 320'(o_rb), 320'(7));
        idle();
        tick();
        check("alu_drop", 320'(fu_vld), 320'(0));

        // Stall skid
        a = rand_pkt('0); b = rand_pkt('0);
        fu_stall = 1'b1; iss_vld = 1'b1; in_pkt = a;
        tick();
        in_pkt = b;
        tick();
        check("skid_rdy0", 320'(iss_rdy), 320'(0));
        iss_vld = 1'b0;
        tick();
        check("skid_holdA", 320'(obs), 320'(a));
        fu_stall = 1'b0;
        tick();
        check("skid_B", 320'(obs), 320'(b));
        check("skid_rdy1", 320'(iss_rdy), 320'(1));
        tick();
        check("skid_empty", 320'(fu_vld), 320'(0));

        // Recovery kills head, skid survives
        fu_stall = 1'b1; iss_vld = 1'b1; in_pkt = rand_pkt(5'b00010);
        tick();
        b = rand_pkt(5'b00001); in_pkt = b;
        tick();
        iss_vld = 1'b0; recov = 1'b1; tag_fix = 5'b00010;
        tick();
        check("rec_vld", 320'(fu_vld), 320'(1));
        check("rec_S", 320'(obs), 320'(b));
        idle();
        tick();

        // Pred correct on head and incoming
        fu_stall = 1'b1; iss_vld = 1'b1; in_pkt = rand_pkt(5'b00110);
        tick();
        pcorr = 1'b1; tag_fix = 5'b00100; in_pkt = rand_pkt(5'b00100);
        tick();
        check("pc_hmask", 320'(o_mask), 320'(5'b00010));
        idle();
        tick();
        check("pc_inmask", 320'(o_mask), 320'(0));
        tick();

        // Incoming squash
        iss_vld = 1'b1; in_pkt = rand_pkt(5'b01000); recov = 1'b1; tag_fix = 5'b01000;
        tick();
        check("insq_vld", 320'(fu_vld), 320'(0));
        check("insq_rdy", 320'(iss_rdy), 320'(1));
        idle();

        // Reset mid-operation with H and S full
        fu_stall = 1'b1; iss_vld = 1'b1; in_pkt = rand_pkt('0);
        tick();
        in_pkt = rand_pkt('0);
        tick();
        idle();
        #2 rst = 1'b0;
        #1;
        check("mrst_vld", 320'(fu_vld), 320'(0));
        check("mrst_rdy", 320'(iss_rdy), 320'(1));
        check("mrst_sel", 320'(o_sel), 320'(FU_SEL_NONE));
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        compare_model();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            iss_vld  = ($urandom_range(0, 9) < 7);
            fu_stall = ($urandom_range(0, 9) < 5);
            recov    = ($urandom_range(0, 9) < 1);
            pcorr    = ($urandom_range(0, 19) < 3);
            tag_fix  = BR_MASK_W'(1) << $urandom_range(0, BR_MASK_W-1);
            in_pkt   = rand_pkt(BR_MASK_W'($urandom));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
